inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time writer for the instruction BRAM that the fetch stage reads. It takes a byte stream from the UART receiver and assembles bytes into 64-bit two-instruction bundles. Each bundle is written to consecutive BRAM addresses through a write port. The core is held in reset until the whole program is written. After that, fetch reads the loaded bundles by address (`pc`).

## Interface
Parameters:
- ADDR_W, 14: width of the BRAM bundle address. Capacity is 2^ADDR_W bundles.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- rx_data  in  8  received byte
- mem_we  out  1  BRAM write enable, single-cycle pulse
- mem_addr  out  ADDR_W  BRAM bundle address
- mem_din  out  64  bundle; [63:32] is slot 0, [31:0] is slot 1
- core_rstn  out  1  active-low reset to the core; low until load completes
- done  out  1  high once load has completed successfully, sticky
- err  out  1  high on a protocol error, sticky

## Operation
- The block has no backpressure. Every rx_valid byte is consumed in the cycle it arrives.
- Byte stream format:
  - Header: 4 bytes, little-endian, giving the bundle count N (32-bit).
  - Payload: N×8 bytes. Each bundle is sent big-endian, so its first byte goes to mem_din[63:56].
- States:
  - HDR: collect 4 header bytes into cnt_total.
    - On the 4th byte with N==0: go to DONE.
    - On the 4th byte with N>2^ADDR_W: go to ERR.
    - Otherwise: go to DATA.
  - DATA: shift bytes into a 64-bit assembly register and count byte_idx 0..7. On byte_idx==7:
    - register the full bundle onto mem_din;
    - pulse mem_we the next cycle at mem_addr = bundle_idx;
    - increment bundle_idx.
    - After the write of bundle N−1, go to DONE (or to CSUM if LOADER_CHECKSUM_EN is defined).
  - DONE: set done=1 and core_rstn=1. Ignore all further rx bytes. Leave only on rstn.
  - ERR: set err=1. core_rstn stays 0. Ignore all rx bytes. Leave only on rstn.
- Address arithmetic:
  - bundle_idx is ADDR_W+1 bits wide, so it can count up to 2^ADDR_W.
  - mem_addr is the low ADDR_W bits.
  - No address wraps, because the header check rejects an oversize N.
- mem_din holds its last value whenever mem_we is low.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_din=0, core_rstn=0, done=0, err=0, state=HDR, all counters 0.
- Latency from the 8th byte's rx_valid cycle (cycle T) to its write:
  - mem_we=1 at T+1, with mem_addr and mem_din stable at T+1.
  - mem_we=0 at T+2 unless another write is due.
- Back-to-back rx_valid on every cycle is legal and must be supported. In that case mem_we pulses every 8 cycles.
- done and core_rstn rise on the same cycle:
  - T+2 after the final bundle byte (no checksum).
  - T+1 after the 4th header byte when N==0.
- err rises on the cycle after the offending byte.
- rstn low in any state, including mid-bundle: on the next edge, drop all partial data, set core_rstn=0, clear done and err, and return to HDR. A write scheduled for that edge is suppressed.
- rx_valid during the mem_we cycle is accepted normally as byte 0 of the next bundle.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A state CSUM follows DATA.
  - A running XOR of all payload bytes is kept; header bytes are excluded.
  - One trailing byte is expected after the payload.
  - If the trailing byte equals the XOR: go to DONE, with done at T+1 after that byte.
  - Otherwise: go to ERR.
  - With N==0, a trailing byte 0x00 is still required.
- Undefined: there is no CSUM state and no trailing byte. DONE follows the final write directly.

## Test plan
- Reset: hold rstn=0 for 3 cycles → all outputs 0 and core_rstn=0; after release, state is HDR.
- Two-bundle load:
  - Send header 02 00 00 00, then 11 22 33 44 55 66 77 88 AA BB CC DD EE FF 00 01, back-to-back.
  - Expect writes addr0=0x1122334455667788 and addr1=0xAABBCCDDEEFF0001, each one cycle after the 8th byte.
  - done=1 and core_rstn=1 at T+2 (checksum undefined).
- N=0: send header 00 00 00 00 → done at T+1 with no mem_we (checksum undefined).
- Oversize: with ADDR_W=4, send header 11 00 00 00 (N=17) → err=1, no writes, core_rstn=0, later bytes ignored.
- Mid-bundle reset: send header 01 00 00 00 plus 5 bytes, then rstn=0 → no write occurs. After reset, send a fresh 1-bundle load → write lands at addr0.
- Checksum (LOADER_CHECKSUM_EN defined): one bundle 01 02 04 08 10 20 40 80.
  - Trailing byte 0xFF → done.
  - Trailing byte 0xFE → err, core_rstn stays 0.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: assembles a UART byte stream (4-byte LE count + big-endian 64-bit bundles) into BRAM writes, holding the core in reset until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_din,
  output logic              core_rstn,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {HDR, DATA, DONE, ERR} state_t;
`endif

  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [1:0]        hdr_cnt;
  logic [31:0]       cnt_total;
  logic [2:0]        byte_idx;
  logic [55:0]       asm_q;
  logic [ADDR_W:0]   bundle_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        hdr_take;
  logic        hdr_last;
  logic [31:0] n_hdr;
  logic        payload_left;
  logic        data_take;

  assign hdr_take     = rx_valid && (state == HDR);
  assign hdr_last     = hdr_take && (hdr_cnt == 2'd3);
  assign n_hdr        = {rx_data, cnt_total[31:8]};
  assign payload_left = (33'(bundle_idx) != {1'b0, cnt_total});
  // Bytes past the last bundle are never treated as payload.
  assign data_take    = rx_valid && (state == DATA) && payload_left;

  assign done      = (state == DONE);
  assign core_rstn = (state == DONE);
  assign err       = (state == ERR);

  always_ff @(posedge clk) begin
    if (!rstn) state <= HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (hdr_last) begin
          if (n_hdr == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else if ({1'b0, n_hdr} > CAP) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        // Final write is on mem_we this cycle; the checksum byte may already be here.
        if (!payload_left) begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_valid) state_nxt = (rx_data == csum) ? DONE : ERR;
          else          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (rx_valid) state_nxt = (rx_data == csum) ? DONE : ERR;
      end
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_cnt    <= '0;
      cnt_total  <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      bundle_idx <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (hdr_take) begin
        cnt_total <= n_hdr;
        hdr_cnt   <= hdr_cnt + 2'd1;
      end
      if (data_take) begin
        byte_idx <= byte_idx + 3'd1;
        asm_q    <= {asm_q[47:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ rx_data;
`endif
        if (byte_idx == 3'd7) begin
          mem_din    <= {asm_q, rx_data};
          mem_we     <= 1'b1;
          mem_addr   <= bundle_idx[ADDR_W-1:0];
          bundle_idx <= bundle_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (ADDR_W=4); checksum steps follow LOADER_CHECKSUM_EN.
module tb_inst_loader;
  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_din;
  logic          core_rstn;
  logic          done;
  logic          err;

  inst_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .core_rstn(core_rstn), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_byte_cyc = 0;

  logic [AW-1:0] wr_addr [$];
  logic [63:0]   wr_data [$];
  int            wr_cyc  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A write is visible in the cycle stamped with its 8th byte's acceptance edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    last_byte_cyc = cyc;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  // Called one cycle after the last payload byte (the write cycle).
  task automatic finish_load(input string tag, input logic [7:0] xsum);
`ifdef LOADER_CHECKSUM_EN
    idle(1);
    check({tag, "_wait_csum"}, 64'(done), 64'd0);
    send_byte(xsum);
    rx_valid = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_core_rstn"}, 64'(core_rstn), 64'd1);
`else
    idle(1);
    check({tag, "_done_t2"}, 64'(done), 64'd1);
    check({tag, "_core_rstn_t2"}, 64'(core_rstn), 64'd1);
    check({tag, "_xsum_unused"}, 64'(xsum == xsum), 64'd1);
`endif
  endtask

  logic [7:0] pay [16];
  int t0, t1;

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h01};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_din", mem_din, 64'd0);
    check("rst_core_rstn", 64'(core_rstn), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_core_rstn", 64'(core_rstn), 64'd0);

    // Two-bundle back-to-back load
    do_reset();
    send_hdr(32'd2);
    for (int i = 0; i < 16; i++) begin
      send_byte(pay[i]);
      if (i == 7) t0 = last_byte_cyc;
      if (i == 15) t1 = last_byte_cyc;
    end
    rx_valid = 1'b0;
    check("b2_we_t1", 64'(mem_we), 64'd1);
    check("b2_done_t1", 64'(done), 64'd0);
    finish_load("b2", 8'h98);
    check("b2_we_low", 64'(mem_we), 64'd0);
    check("b2_nwr", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("b2_addr0", 64'(wr_addr[0]), 64'd0);
      check("b2_data0", wr_data[0], 64'h1122334455667788);
      check("b2_cyc0", 64'(wr_cyc[0]), 64'(t0));
      check("b2_addr1", 64'(wr_addr[1]), 64'd1);
      check("b2_data1", wr_data[1], 64'hAABBCCDDEEFF0001);
      check("b2_cyc1", 64'(wr_cyc[1]), 64'(t1));
    end
    check("b2_din_hold", mem_din, 64'hAABBCCDDEEFF0001);
    for (int i = 0; i < 9; i++) send_byte(8'h5A);
    idle(2);
    check("b2_ignore_nwr", 64'(wr_addr.size()), 64'd2);
    check("b2_done_sticky", 64'(done), 64'd1);

    // N = 0
    do_reset();
    send_hdr(32'd0);
    rx_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    check("n0_wait_csum", 64'(done), 64'd0);
    send_byte(8'h00);
    rx_valid = 1'b0;
`endif
    check("n0_done_t1", 64'(done), 64'd1);
    check("n0_core_rstn", 64'(core_rstn), 64'd1);
    idle(2);
    check("n0_nwr", 64'(wr_addr.size()), 64'd0);

    // Oversize: N=17 > 2^4
    do_reset();
    send_hdr(32'd17);
    rx_valid = 1'b0;
    check("ovr_err_t1", 64'(err), 64'd1);
    check("ovr_core_rstn", 64'(core_rstn), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    idle(2);
    check("ovr_nwr", 64'(wr_addr.size()), 64'd0);
    check("ovr_err_sticky", 64'(err), 64'd1);
    check("ovr_done", 64'(done), 64'd0);

    // Full capacity: N=16 fills addresses 0..15
    do_reset();
    send_hdr(32'd16);
    for (int i = 0; i < 128; i++) send_byte(8'(i));
    rx_valid = 1'b0;
    check("cap_err", 64'(err), 64'd0);
    finish_load("cap", 8'h00);
    check("cap_nwr", 64'(wr_addr.size()), 64'd16);
    if (wr_addr.size() == 16) begin
      check("cap_addr15", 64'(wr_addr[15]), 64'd15);
      check("cap_data15", wr_data[15], 64'h78797A7B7C7D7E7F);
      check("cap_data3", wr_data[3], 64'h18191A1B1C1D1E1F);
    end

    // Mid-bundle reset drops partial data
    do_reset();
    send_hdr(32'd1);
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
    rx_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid_we", 64'(mem_we), 64'd0);
    check("mid_core_rstn", 64'(core_rstn), 64'd0);
    send_hdr(32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'hA1 + 8'(i));
    rx_valid = 1'b0;
    finish_load("mid", 8'h08);
    check("mid_nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      check("mid_addr0", 64'(wr_addr[0]), 64'd0);
      check("mid_data0", wr_data[0], 64'hA1A2A3A4A5A6A7A8);
    end

`ifdef LOADER_CHECKSUM_EN
    // Good checksum, trailing byte back-to-back with the last payload byte
    do_reset();
    send_hdr(32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'h01 << i);
    send_byte(8'hFF);
    rx_valid = 1'b0;
    check("cs_ok_done", 64'(done), 64'd1);
    check("cs_ok_err", 64'(err), 64'd0);

    // Bad checksum
    do_reset();
    send_hdr(32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'h01 << i);
    idle(2);
    send_byte(8'hFE);
    rx_valid = 1'b0;
    check("cs_bad_err", 64'(err), 64'd1);
    check("cs_bad_done", 64'(done), 64'd0);
    check("cs_bad_core_rstn", 64'(core_rstn), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
